hazard_scheduler: RTL

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

---
 rtl/hazard_scheduler_if.sv | 31 +++
 rtl/hazard_scheduler.sv | 130 +++++++++++++
 2 files changed

// File: rtl/hazard_scheduler_if.sv
// Pipeline <-> hazard_scheduler signal bundle. master = pipeline side, slave = scheduler.
interface hazard_scheduler_if;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, jump_d, pc_src_d;
  logic       muldiv_start_e;
  logic       mem_access_m, mem_ready_m;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e;
  logic       forward_a_d, forward_b_d;
  logic [1:0] forward_a_e, forward_b_e;
  logic       muldiv_busy;

  modport master (
    output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
           branch_d, jump_d, pc_src_d, muldiv_start_e, mem_access_m, mem_ready_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
           forward_a_d, forward_b_d, forward_a_e, forward_b_e, muldiv_busy
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
           branch_d, jump_d, pc_src_d, muldiv_start_e, mem_access_m, mem_ready_m,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
           forward_a_d, forward_b_d, forward_a_e, forward_b_e, muldiv_busy
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Hazard detection, forwarding select and multi-cycle (mult/div, memory wait) stall control.
// Macro HAZARD_SCHEDULER_FWD_EN enables forwarding; without it RAW dependencies stall in decode.
module hazard_scheduler #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              clr,
  hazard_scheduler_if.slave hz
);
  typedef enum logic [1:0] {RUN, MULDIV, MEMWAIT} state_t;
  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dec_hit_e, dec_hit_m;
  logic       lw_stall, br_stall, dep_stall, run_stall, mem_wait;
  logic       stall_f, stall_d, stall_e, stall_m, flush_e, busy;
  logic       fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;

  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  assign dec_hit_e = hit(hz.rs_d, hz.write_reg_e) || hit(hz.rt_d, hz.write_reg_e);
  assign dec_hit_m = hit(hz.rs_d, hz.write_reg_m) || hit(hz.rt_d, hz.write_reg_m);
  assign lw_stall  = hz.mem_to_reg_e && dec_hit_e;
  assign br_stall  = hz.branch_d &&
                     ((hz.reg_write_e && dec_hit_e) || (hz.mem_to_reg_m && dec_hit_m));
  assign mem_wait  = hz.mem_access_m && !hz.mem_ready_m;

`ifdef HAZARD_SCHEDULER_FWD_EN
  function automatic logic [1:0] sel_e(input logic [4:0] src,
                                       input logic rw_m, input logic [4:0] wr_m,
                                       input logic rw_w, input logic [4:0] wr_w);
    if (rw_m && hit(src, wr_m)) return 2'b10;
    if (rw_w && hit(src, wr_w)) return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a_e   = sel_e(hz.rs_e, hz.reg_write_m, hz.write_reg_m, hz.reg_write_w, hz.write_reg_w);
  assign fwd_b_e   = sel_e(hz.rt_e, hz.reg_write_m, hz.write_reg_m, hz.reg_write_w, hz.write_reg_w);
  assign fwd_a_d   = hz.reg_write_m && hit(hz.rs_d, hz.write_reg_m);
  assign fwd_b_d   = hz.reg_write_m && hit(hz.rt_d, hz.write_reg_m);
  assign dep_stall = 1'b0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{hz.rs_e, hz.rt_e, hz.write_reg_w, hz.reg_write_w};
  assign fwd_a_e    = '0;
  assign fwd_b_e    = '0;
  assign fwd_a_d    = 1'b0;
  assign fwd_b_d    = 1'b0;
  // W needs no stall: the register file writes in the first half-cycle.
  assign dep_stall  = (hz.reg_write_e && dec_hit_e) || (hz.reg_write_m && dec_hit_m);
`endif

  assign run_stall = lw_stall || br_stall || dep_stall;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_e = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      RUN: begin
        stall_f = run_stall;
        stall_d = run_stall;
        flush_e = run_stall;
        if (mem_wait) begin
          state_d = MEMWAIT;
        end else if (hz.muldiv_start_e) begin
          // Busy covers the issue cycle so it spans MULDIV_CYCLES in total.
          state_d = MULDIV;
          cnt_d   = CNT_LOAD;
          busy    = 1'b1;
        end
      end
      MEMWAIT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        if (hz.mem_ready_m) state_d = RUN;
      end
      MULDIV: begin
        if (cnt_q != 4'd0) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          busy    = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (clr) begin
      stall_e = 1'b0;
      stall_m = 1'b0;
      busy    = 1'b0;
    end
  end

  assign hz.stall_f     = stall_f;
  assign hz.stall_d     = stall_d;
  assign hz.stall_e     = stall_e;
  assign hz.stall_m     = stall_m;
  assign hz.flush_d     = (hz.pc_src_d || hz.jump_d) && !stall_d;
  assign hz.flush_e     = flush_e;
  assign hz.forward_a_d = fwd_a_d;
  assign hz.forward_b_d = fwd_b_d;
  assign hz.forward_a_e = fwd_a_e;
  assign hz.forward_b_e = fwd_b_e;
  assign hz.muldiv_busy = busy;
endmodule
